// File: rtl/chip8_rand_arbiter.sv
// -----------------------------------------------------------------------------
// chip8_rand_arbiter
//
// Shares one 16-bit pseudo-random generator among NUM_REQ requesters using a
// round-robin request/acknowledge handshake. After every grant the arbiter
// waits MIN_GAP cycles (COOL) so the generator advances between draws. A
// generator value of zero marks a reseed cycle, and no grant is made in that
// cycle. The winner's 8-bit mask is applied to the source byte and the result
// is returned with the one-cycle ack pulse.
//
// Optional feature macro: CHIP8_RAND_FOLD_EN
//   defined     : source byte = rand_num[15:8] ^ rand_num[7:0]
//   not defined : source byte = rand_num[7:0]
//
// Parameters
//   NUM_REQ   number of requesters (1..4)
//   MIN_GAP   cooldown cycles after each grant (1..15)
//
// Ports
//   cpu_clk    in   clock, all logic on the rising edge
//   reset      in   synchronous active-high reset
//   rand_num   in   current generator value
//   req        in   level request per requester
//   mask       in   per-requester mask, requester i uses [8i+7:8i]
//   ack        out  one-hot one-cycle grant pulse (registered)
//   rand_data  out  masked random byte, valid while ack != 0 (registered)
//   busy       out  high during the cooldown window (registered)
// -----------------------------------------------------------------------------
module chip8_rand_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int MIN_GAP = 2
) (
   input  logic                 cpu_clk,
   input  logic                 reset,
   input  logic [15:0]          rand_num,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] mask,
   output logic [NUM_REQ-1:0]   ack,
   output logic [7:0]           rand_data,
   output logic                 busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [0:0] {
      ST_READY = 1'b0,
      ST_COOL  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [IW-1:0]      last_q, last_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [7:0]         rand_data_q, rand_data_d;
   logic               busy_q, busy_d;

   logic [7:0]         mask_arr_s [NUM_REQ];
   logic [7:0]         src_s;
   logic               win_found_s;
   logic [IW-1:0]      win_idx_s;
   logic [IW-1:0]      cand_idx_s;

   // Split the flat mask bus into one byte per requester.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_mask
      assign mask_arr_s[g] = mask[g*8 +: 8];
   end

   // Source byte taken from the generator; the fold mixes in the upper half.
   always_comb begin
`ifdef CHIP8_RAND_FOLD_EN
      src_s = rand_num[15:8] ^ rand_num[7:0];
`else
      src_s = rand_num[7:0];
`endif
   end

   // Round-robin search starting just above the last winner, wrapping around.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_idx_s  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_idx_s = IW'((int'(last_q) + k) % NUM_REQ);
         if (!win_found_s && req[cand_idx_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_idx_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Next-state and output computation for the READY/COOL controller.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      ack_d       = '0;
      rand_data_d = rand_data_q;
      busy_d      = busy_q;
      case (state_q)
         ST_READY: begin
            // A zero generator value is a reseed cycle: hold off the grant.
            if (win_found_s && (rand_num != 16'h0000)) begin
               ack_d[win_idx_s] = 1'b1;
               rand_data_d      = src_s & mask_arr_s[win_idx_s];
               last_d           = win_idx_s;
               cnt_d            = 4'(MIN_GAP);
               state_d          = ST_COOL;
               busy_d           = 1'b1;
            end else begin
               busy_d = 1'b0;
            end
         end
         ST_COOL: begin
            // "<= 1" also recovers from a corrupted zero count.
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_READY;
               busy_d  = 1'b0;
            end else begin
               cnt_d  = cnt_q - 4'd1;
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_READY;
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset leaves requester 0 with top priority.
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         state_q     <= ST_READY;
         cnt_q       <= 4'd0;
         last_q      <= IW'(NUM_REQ - 1);
         ack_q       <= '0;
         rand_data_q <= 8'h00;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         ack_q       <= ack_d;
         rand_data_q <= rand_data_d;
         busy_q      <= busy_d;
      end
   end

   assign ack       = ack_q;
   assign rand_data = rand_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_chip8_rand_arbiter.sv
// -----------------------------------------------------------------------------
// tb_chip8_rand_arbiter
//
// Self-checking bench for chip8_rand_arbiter (NUM_REQ=2, MIN_GAP=2). A
// behavioural model predicts ack/busy/rand_data from the arbitration rules:
// a grant is possible in any cycle at or after the end of the previous
// cooldown, the winner is the first requester above the last winner, and the
// cooldown lasts MIN_GAP cycles from the ack cycle. Directed scenarios pin the
// model with literal values, then a randomized phase runs against the model.
// -----------------------------------------------------------------------------
module tb_chip8_rand_arbiter;

   localparam int NR = 2;
   localparam int MG = 2;

   logic            cpu_clk = 1'b0;
   logic            reset;
   logic [15:0]     rand_num;
   logic [NR-1:0]   req;
   logic [NR*8-1:0] mask;
   logic [NR-1:0]   ack;
   logic [7:0]      rand_data;
   logic            busy;

   int n_pass  = 0;
   int n_total = 0;

   // Model state
   int            cyc        = 0;
   int            m_ready_at = 0;
   int            m_last     = NR - 1;
   bit            model_on   = 1'b0;
   logic [NR-1:0] exp_ack;
   logic [7:0]    exp_data;
   logic          exp_busy;
   bit            exp_data_valid;

   always #5 cpu_clk = ~cpu_clk;

   chip8_rand_arbiter #(
      .NUM_REQ (NR),
      .MIN_GAP (MG)
   ) dut (
      .cpu_clk   (cpu_clk),
      .reset     (reset),
      .rand_num  (rand_num),
      .req       (req),
      .mask      (mask),
      .ack       (ack),
      .rand_data (rand_data),
      .busy      (busy)
   );

   function automatic logic [7:0] src_of(input logic [15:0] v);
`ifdef CHIP8_RAND_FOLD_EN
      return v[15:8] ^ v[7:0];
`else
      return v[7:0];
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Model update for one rising edge, using the inputs sampled at that edge.
   task automatic model_edge();
      int  w;
      int  c;
      bit  found;
      cyc++;
      exp_ack        = '0;
      exp_data_valid = 1'b0;
      if (reset) begin
         m_last         = NR - 1;
         m_ready_at     = cyc;
         exp_data       = 8'h00;
         exp_data_valid = 1'b1;
         exp_busy       = 1'b0;
         model_on       = 1'b1;
      end else begin
         if (model_on && (cyc - 1) >= m_ready_at && req != '0 && rand_num != 16'h0000) begin
            found = 1'b0;
            w     = 0;
            for (int k = 1; k <= NR; k++) begin
               c = (m_last + k) % NR;
               if (!found && req[c]) begin
                  found = 1'b1;
                  w     = c;
               end
            end
            exp_ack[w]     = 1'b1;
            exp_data       = src_of(rand_num) & mask[w*8 +: 8];
            exp_data_valid = 1'b1;
            m_last         = w;
            m_ready_at     = cyc + MG;
         end
         exp_busy = (cyc < m_ready_at);
      end
   endtask

   // One clock: advance the model, then compare DUT outputs just after the edge.
   task automatic step();
      @(posedge cpu_clk);
      model_edge();
      #1;
      if (model_on) begin
         chk("model_ack", 32'(ack), 32'(exp_ack));
         chk("model_busy", 32'(busy), 32'(exp_busy));
         if (exp_data_valid) begin
            chk("model_rand_data", 32'(rand_data), 32'(exp_data));
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      step();
      reset = 1'b0;
   endtask

   logic [1:0] ack_tab  [0:7] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
   logic       busy_tab [0:7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [7:0] exp_first;

   initial begin
      reset    = 1'b1;
      req      = '0;
      rand_num = 16'hF5D2;
      mask     = 16'h0000;
      step();
      step();
      chk("reset_ack", 32'(ack), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_data", 32'(rand_data), 32'h00);

      // Basic masked draw
      reset = 1'b0;
      req   = 2'b01;
      mask  = 16'h000F;
      step();
`ifdef CHIP8_RAND_FOLD_EN
      exp_first = 8'h07;
`else
      exp_first = 8'h02;
`endif
      chk("first_ack", 32'(ack), 32'h1);
      chk("first_data", 32'(rand_data), 32'(exp_first));
      req = '0;

      // Continuous demand from both requesters
      do_reset();
      req      = 2'b11;
      rand_num = 16'h1357;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("rr_ack", 32'(ack), 32'(ack_tab[i]));
         chk("rr_busy", 32'(busy), 32'(busy_tab[i]));
      end

      // Zero generator sample delays the grant by one cycle
      do_reset();
      req      = 2'b01;
      rand_num = 16'h0000;
      step();
      chk("zero_noack", 32'(ack), 32'h0);
      rand_num = 16'h1234;
      step();
      chk("zero_then_ack", 32'(ack), 32'h1);
      req = '0;

      // Reset in the same cycle as an ack
      do_reset();
      req      = 2'b10;
      rand_num = 16'hABCD;
      mask     = 16'hFFFF;
      step();
      chk("pre_reset_ack", 32'(ack), 32'h2);
      reset = 1'b1;
      step();
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_data", 32'(rand_data), 32'h00);
      reset = 1'b0;
      req   = 2'b11;
      step();
      chk("post_reset_prio", 32'(ack), 32'h1);
      req = '0;

      // Request raised during cooldown waits for READY
      do_reset();
      req = 2'b01;
      step();
      chk("cool_first", 32'(ack), 32'h1);
      req = 2'b10;
      step();
      chk("cool_hold_ack", 32'(ack), 32'h0);
      chk("cool_hold_busy", 32'(busy), 32'h1);
      step();
      chk("cool_ready_ack", 32'(ack), 32'h0);
      chk("cool_ready_busy", 32'(busy), 32'h0);
      step();
      chk("cool_grant", 32'(ack), 32'h2);
      req = '0;

      // Zero mask on requester 1
      do_reset();
      req      = 2'b10;
      mask     = 16'h00FF;
      rand_num = 16'h9E3B;
      step();
      chk("zmask_ack", 32'(ack), 32'h2);
      chk("zmask_data", 32'(rand_data), 32'h00);
      req = '0;
      step();
      step();

      // Randomized phase against the model
      for (int i = 0; i < 800; i++) begin
         reset    = ($urandom_range(0, 59) == 0);
         req      = NR'($urandom);
         rand_num = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         mask     = 16'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/chip8_rand_arbiter.md
# chip8_rand_arbiter

Shares the single 16-bit pseudo-random source among several requesters (CPU CXNN execution unit, debug/test port, etc.) with a round-robin request/acknowledge handshake. Guarantees each draw sees a source value that has advanced at least `MIN_GAP` steps since the previous draw. Applies the requester's 8-bit CXNN mask and returns the masked byte. Sits between `cpu_clk`-domain requesters and the random generator output.

## Interface
- `NUM_REQ`, 2: number of requesters; legal range 1..4.
- `MIN_GAP`, 2: cooldown cycles after each grant before the next grant is allowed; legal range 1..15.
---
- `cpu_clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rand_num`  in  16  current generator value; sampled every cycle.
- `req`  in  NUM_REQ  level request per requester; held until its `ack` is seen.
- `mask`  in  NUM_REQ*8  per-requester mask; requester i uses bits [8i+7:8i].
- `ack`  out  NUM_REQ  one-hot, one-cycle grant pulse; registered.
- `rand_data`  out  8  masked random byte; valid only in the cycle `ack` is nonzero; registered.
- `busy`  out  1  high while in COOL; registered.

## Operation
- Two-state FSM: READY, COOL. Cooldown counter `cnt` is 4 bits.
- READY, no pending request (`req`==0): stay READY; `ack`=0.
- READY, `rand_num`==16'h0000 (generator reseed cycle): no grant; stay READY regardless of `req`.
- READY, `req`!=0, `rand_num`!=0: pick winner i by round robin, searching upward (with wrap) from `last+1`; at the edge set `ack[i]`=1, `rand_data`=src & `mask[i]`, `last`=i, `cnt`=MIN_GAP, state=COOL, `busy`=1.
- `src` = `rand_num[7:0]` (see Configuration).
- COOL: `ack`=0; `cnt` decrements each edge; the edge where `cnt`==1 moves to READY (`cnt`=0, `busy`=0). Requests are ignored in COOL.
- `rand_data` holds its last value when `ack`=0; only meaningful while `ack`!=0.
- Requesters must drop `req` no later than the edge following their `ack` pulse. MIN_GAP>=1 guarantees the same request is never granted twice.
- `req` bits at or above NUM_REQ do not exist; mask bits of non-requesting slots are ignored.
- Reset (at any time, including while `ack` is high or in COOL): next edge gives state=READY, `cnt`=0, `ack`=0, `rand_data`=8'h00, `busy`=0, `last`=NUM_REQ-1, so requester 0 has top priority.

## Timing
- Grant latency: `req` high in a READY cycle t with `rand_num`!=0 gives `ack` high in cycle t+1; `rand_data` reflects `rand_num` and `mask` sampled in cycle t.
- Minimum spacing between consecutive `ack` pulses: MIN_GAP+1 cycles. With MIN_GAP=2, acks occur at cycles 1, 4, 7 … under continuous demand.
- `busy` is high from the `ack` cycle through the last COOL cycle (MIN_GAP cycles).
- The zero check delays a grant by exactly one cycle per zero sample.
- No combinational path from inputs to outputs.

## Configuration
- `CHIP8_RAND_FOLD_EN` defined: `src` = `rand_num[15:8]` ^ `rand_num[7:0]`, so all 16 source bits contribute.
- Not defined: `src` = `rand_num[7:0]`.
- No other behaviour changes.

## Test plan
- Reset, then `req`=2'b01, `mask[7:0]`=8'h0F, `rand_num`=16'hF5D2: `ack`=2'b01 one cycle later with `rand_data`=8'h02. With CHIP8_RAND_FOLD_EN: 8'h07.
- `req`=2'b11 held continuously, MIN_GAP=2: `ack` sequence 01, 10, 01 at cycles 1, 4, 7; `busy` high in cycles 1–2, 4–5, 7–8.
- `rand_num`=16'h0000 for one cycle while `req`=2'b01 in READY: no ack that cycle; `ack` appears one cycle after `rand_num` becomes nonzero.
- `reset` asserted in the same cycle as `ack`=2'b10: next cycle `ack`=0, `busy`=0, `rand_data`=8'h00; then `req`=2'b11 grants requester 0 first.
- `req[1]` raised during COOL, with `req[0]` idle: no ack until `busy` falls; `ack`=2'b10 the cycle after READY is reached.
- `mask[15:8]`=8'h00, `req`=2'b10: `ack`=2'b10 with `rand_data`=8'h00 for any `rand_num`.
